// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered UART transmitter: byte FIFO feeding a start/data/parity/stop serializer
module uart_tx_fifo #(
  parameter int AW        = 4,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          baud_en,
  input  logic [7:0]    din,
  input  logic          wrn,
  output logic          txd,
  output logic          send_over,
  output logic          busy,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overrun
);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

  logic [7:0]    mem_q [2**AW];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d, empty_q, empty_d;
  logic          overrun_q, overrun_d;
  state_t        state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic          stop_idx_q, stop_idx_d;
  logic          txd_q, txd_d;
  logic          send_over_q, send_over_d;
  logic          wr_en, pop, par_bit;

  // full is judged on the registered flag, so a write that races a pop is still dropped
  assign wr_en   = !wrn && !full_q;
  assign par_bit = (^shift_q) ^ (PARITY == 1);

  always_comb begin
    wr_ptr_d  = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    full_d    = (count_d == DEPTH);
    empty_d   = (count_d == '0);
    overrun_d = !wrn && full_q;
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    stop_idx_d  = stop_idx_q;
    txd_d       = txd_q;
    send_over_d = 1'b0;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (baud_en && !empty_q) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          txd_d   = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (baud_en) begin
          txd_d     = shift_q[0];
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (baud_en) begin
          if (bit_idx_q == 3'd7) begin
            stop_idx_d = 1'b0;
            if (PARITY != 0) begin
              txd_d   = par_bit;
              state_d = PAR;
            end else begin
              txd_d   = 1'b1;
              state_d = STOP;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            txd_d     = shift_q[bit_idx_q + 3'd1];
          end
        end
      end
      PAR: begin
        if (baud_en) begin
          txd_d      = 1'b1;
          stop_idx_d = 1'b0;
          state_d    = STOP;
        end
      end
      STOP: begin
        if (baud_en) begin
          if (stop_idx_q == 1'(STOP_BITS - 1)) begin
            send_over_d = 1'b1;
            // chain straight into the next start bit when more data is waiting
            if (!empty_q) begin
              pop     = 1'b1;
              shift_d = mem_q[rd_ptr_q];
              txd_d   = 1'b0;
              state_d = START;
            end else begin
              txd_d   = 1'b1;
              state_d = IDLE;
            end
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: begin
        txd_d   = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      overrun_q   <= 1'b0;
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      stop_idx_q  <= 1'b0;
      txd_q       <= 1'b1;
      send_over_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      overrun_q   <= overrun_d;
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      stop_idx_q  <= stop_idx_d;
      txd_q       <= txd_d;
      send_over_q <= send_over_d;
    end
  end

  assign txd       = txd_q;
  assign send_over = send_over_q;
  assign busy      = (state_q != IDLE);
  assign full      = full_q;
  assign empty     = empty_q;
  assign count     = count_q;
  assign overrun   = overrun_q;

endmodule
